// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: a small register file sets per-channel modes.
// A shared prescaler/PWM counter pair drives off/on/blink/pwm LED outputs.
module led_pwm_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [NUM_CH-1:0] led
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } chMode_e;

    logic                  ctrlEn_q, ctrlEn_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [1:0]            chMode_q [NUM_CH];
    logic [1:0]            chMode_d [NUM_CH];
    logic [PWM_BITS-1:0]   chDuty_q [NUM_CH];
    logic [PWM_BITS-1:0]   chDuty_d [NUM_CH];

    logic [PRESC_BITS-1:0] prescCnt_q, prescCnt_d;
    logic [PWM_BITS-1:0]   pwmCnt_q, pwmCnt_d;
    logic                  blink_q, blink_d;
    logic [NUM_CH-1:0]     led_q, led_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  tick;
    logic                  prescWrite;
    logic                  unusedWdata;

    // Upper write-data bits only matter for wide parameter choices.
    assign unusedWdata = ^wdata;

    assign tick       = ctrlEn_q && (prescCnt_q == presc_q);
    assign prescWrite = wr_en && (addr == 8'd1);

    // Register file write decode; unmapped addresses leave everything untouched.
    always_comb begin
        ctrlEn_d = ctrlEn_q;
        presc_d  = presc_q;
        chMode_d = chMode_q;
        chDuty_d = chDuty_q;
        if (wr_en) begin
            if (addr == 8'd0) begin
                ctrlEn_d = wdata[0];
            end
            if (addr == 8'd1) begin
                presc_d = wdata[PRESC_BITS-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == 8'(i + 2)) begin
                    chMode_d[i] = wdata[1:0];
                    chDuty_d[i] = wdata[PWM_BITS+1:2];
                end
            end
        end
    end

    // Prescaler, PWM counter and blink phase; all held at zero while disabled.
    always_comb begin
        prescCnt_d = prescCnt_q + PRESC_BITS'(1);
        pwmCnt_d   = pwmCnt_q;
        blink_d    = blink_q;
        if (tick) begin
            prescCnt_d = '0;
            pwmCnt_d   = pwmCnt_q + PWM_BITS'(1);
            if (pwmCnt_q == '1) begin
                blink_d = ~blink_q;
            end
        end
        if (prescWrite) begin
            prescCnt_d = '0;
        end
        if (!ctrlEn_q) begin
            prescCnt_d = '0;
            pwmCnt_d   = '0;
            blink_d    = 1'b0;
        end
    end

    // Per-channel LED function from the current register and counter state.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (chMode_e'(chMode_q[i]))
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_q;
                MODE_PWM:   led_d[i] = (pwmCnt_q < chDuty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
        if (!ctrlEn_q) begin
            led_d = '0;
        end
    end

    // Read mux sees the pre-write register values, so read-during-write returns old data.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = rd_en;
        if (rd_en) begin
            if (addr == 8'd0) begin
                rdata_d = {31'd0, ctrlEn_q};
            end
            if (addr == 8'd1) begin
                rdata_d = 32'(presc_q);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == 8'(i + 2)) begin
                    rdata_d = 32'({chDuty_q[i], chMode_q[i]});
                end
            end
        end
    end

    // State register; reset overrides any access in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlEn_q   <= 1'b0;
            presc_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                chMode_q[i] <= '0;
                chDuty_q[i] <= '0;
            end
            prescCnt_q <= '0;
            pwmCnt_q   <= '0;
            blink_q    <= 1'b0;
            led_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            ctrlEn_q   <= ctrlEn_d;
            presc_q    <= presc_d;
            chMode_q   <= chMode_d;
            chDuty_q   <= chDuty_d;
            prescCnt_q <= prescCnt_d;
            pwmCnt_q   <= pwmCnt_d;
            blink_q    <= blink_d;
            led_q      <= led_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign led    = led_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Testbench for led_pwm_ctrl: register reads are scored against a shadow model
// through an expectation queue, LED behaviour is measured over whole periods.
module tb_led_pwm_ctrl;

    localparam int NUM_CH     = 8;
    localparam int PWM_BITS   = 8;
    localparam int PRESC_BITS = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic              rd_en;
    logic [7:0]        addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [NUM_CH-1:0] led;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expQueue [$];
    logic [31:0] shadow [256];
    logic        expValid = 1'b0;

    led_pwm_ctrl #(
        .NUM_CH     (NUM_CH),
        .PWM_BITS   (PWM_BITS),
        .PRESC_BITS (PRESC_BITS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Read data must appear exactly one cycle after an accepted read strobe.
    always @(posedge clk) expValid <= rd_en && !reset;

    // Scoreboard: pop one expectation per expected read response.
    always @(negedge clk) begin
        logic [31:0] expData;
        if (rvalid || expValid) begin
            checkOutput("rvalid", 32'(rvalid), 32'(expValid));
        end
        if (expValid) begin
            if (expQueue.size() == 0) begin
                checkOutput("queue_underflow", 32'(expQueue.size()), 32'd1);
            end else begin
                expData = expQueue.pop_front();
                if (rvalid) begin
                    checkOutput("rdata", rdata, expData);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modelWrite(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'd0) begin
            shadow[a] = d & 32'h1;
        end else if (a == 8'd1) begin
            shadow[a] = d & 32'hFFFF;
        end else if (int'(a) < 2 + NUM_CH) begin
            shadow[a] = d & 32'h3FF;
        end
    endtask

    // One bus cycle; expected read data is the shadow value before the write.
    task automatic applyStimulus(input logic doWr, input logic doRd, input logic [7:0] a, input logic [31:0] d);
        wr_en = doWr;
        rd_en = doRd;
        addr  = a;
        wdata = d;
        if (doRd && !reset) expQueue.push_back(shadow[a]);
        if (doWr && !reset) modelWrite(a, d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic countHigh(input int ch, input int n, output int highs);
        highs = 0;
        repeat (n) begin
            if (led[ch]) highs++;
            waitCycles(1);
        end
    endtask

    task automatic waitLedChange(input int ch, input int limit, output int cycles);
        logic prev;
        prev   = led[ch];
        cycles = 0;
        while (led[ch] == prev && cycles < limit) begin
            waitCycles(1);
            cycles++;
        end
    endtask

    initial begin
        int highs;
        int cycles;
        int run;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        // Reset state and basic reads
        waitCycles(2);
        checkOutput("reset_led", 32'(led), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd1, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd2, 32'd0);
        waitCycles(2);
        checkOutput("idle_led", 32'(led), 32'd0);

        // Register masking, unmapped addresses, read-during-write
        applyStimulus(1'b1, 1'b0, 8'd0, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b1, 8'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd1, 32'hABCD_1234);
        applyStimulus(1'b0, 1'b1, 8'd1, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd9, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 8'd9, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd10, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 8'd10, 32'd0);
        applyStimulus(1'b1, 1'b1, 8'd5, 32'h5);
        applyStimulus(1'b0, 1'b1, 8'd5, 32'd0);
        applyStimulus(1'b1, 1'b1, 8'd200, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 8'd200, 32'd0);
        for (int a = 0; a <= 10; a++) applyStimulus(1'b0, 1'b1, 8'(a), 32'd0);
        waitCycles(2);
        checkOutput("disabled_led", 32'(led), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd1, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd9, 32'd0);

        // Channel 0 on: visible two edges after the enabling write
        applyStimulus(1'b1, 1'b0, 8'd2, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h1);
        checkOutput("on_led_edge1", 32'(led), 32'h00);
        waitCycles(1);
        checkOutput("on_led_edge2", 32'(led), 32'h01);

        // PWM on channel 1, PRESC=0
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd2, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd3, (32'd64 << 2) | 32'd3);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h1);
        waitCycles(3);
        countHigh(1, 256, highs);
        checkOutput("pwm64_win1", 32'(highs), 32'd64);
        countHigh(1, 256, highs);
        checkOutput("pwm64_win2", 32'(highs), 32'd64);
        checkOutput("pwm_other_bits", 32'(led & 8'hFD), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd3, 32'd3);
        waitCycles(2);
        countHigh(1, 256, highs);
        checkOutput("pwm_duty0", 32'(highs), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd3, 32'h3FF);
        waitCycles(2);
        countHigh(1, 256, highs);
        checkOutput("pwm_duty255", 32'(highs), 32'd255);

        // Blink on channel 2, PRESC=3
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd3, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd1, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'd4, 32'd2);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h1);
        checkOutput("blink_start", 32'(led[2]), 32'd0);
        waitLedChange(2, 1100, cycles);
        checkOutput("blink_first", 32'(cycles), 32'd1025);
        checkOutput("blink_level1", 32'(led[2]), 32'd1);
        waitLedChange(2, 1100, cycles);
        checkOutput("blink_period1", 32'(cycles), 32'd1024);
        waitLedChange(2, 1100, cycles);
        checkOutput("blink_period2", 32'(cycles), 32'd1024);

        // Restart from zero, then reset mid-run
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd4, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'd1, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd2, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'd3, (32'd64 << 2) | 32'd3);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h1);
        checkOutput("restart_led", 32'(led), 32'd0);
        waitCycles(1);
        run = 0;
        while (led[1] && run < 300) begin
            run++;
            waitCycles(1);
        end
        checkOutput("restart_run", 32'(run), 32'd64);
        waitCycles(20);
        checkOutput("active_led0", 32'(led[0]), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'd6, 32'h1);
        checkOutput("midreset_led", 32'(led), 32'd0);
        checkOutput("midreset_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        reset = 1'b0;
        waitCycles(3);
        checkOutput("postreset_led", 32'(led), 32'd0);
        for (int a = 0; a < 2 + NUM_CH; a++) applyStimulus(1'b0, 1'b1, 8'(a), 32'd0);

        // EN dropped mid-run: LED clears one edge after the new CTRL value lands
        applyStimulus(1'b1, 1'b0, 8'd2, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h1);
        waitCycles(4);
        checkOutput("reenable_led0", 32'(led[0]), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'h0);
        checkOutput("disable_edge1", 32'(led[0]), 32'd1);
        waitCycles(1);
        checkOutput("disable_edge2", 32'(led), 32'd0);

        waitCycles(3);
        checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
